// File: rtl/route_learntbl.sv
// Learning MAC table for an NETH-port switch: round-robin learn arbitration,
// age-based eviction, and a single-stage lookup pipe with ready/valid results.

module route_learntbl_entry #(
  parameter int MACW  = 48,
  parameter int PW    = 2,
  parameter int LGAGE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             tick,
  input  logic [MACW-1:0]  wr_mac,
  input  logic [PW-1:0]    wr_port,
  output logic             vld,
  output logic             vld_nxt,
  output logic [LGAGE-1:0] age,
  output logic [MACW-1:0]  mac,
  output logic [PW-1:0]    port
);
  logic             vld_q, vld_d;
  logic [LGAGE-1:0] age_q, age_d;
  logic [MACW-1:0]  mac_q, mac_d;
  logic [PW-1:0]    port_q, port_d;

  // A write in the same cycle as a tick wins: the entry was just refreshed.
  always_comb begin
    vld_d  = vld_q;
    age_d  = age_q;
    mac_d  = mac_q;
    port_d = port_q;
    if (wr_en) begin
      vld_d  = 1'b1;
      age_d  = '1;
      mac_d  = wr_mac;
      port_d = wr_port;
    end else if (tick && vld_q) begin
      if (age_q <= LGAGE'(1)) begin
        vld_d = 1'b0;
        age_d = '0;
      end else begin
        age_d = age_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      age_q <= '0;
    end else begin
      vld_q <= vld_d;
      age_q <= age_d;
    end
  end

  always_ff @(posedge clk) begin
    mac_q  <= mac_d;
    port_q <= port_d;
  end

  assign vld     = vld_q;
  assign vld_nxt = vld_d;
  assign age     = age_q;
  assign mac     = mac_q;
  assign port    = port_q;
endmodule

module route_learntbl #(
  parameter int              NETH           = 4,
  parameter int              MACW           = 48,
  parameter int              LGTBL          = 6,
  parameter int              LGAGE          = 4,
  parameter int              LGTICK         = 20,
  parameter logic [NETH-1:0] BROADCAST_PORT = '1,
  parameter bit              OPT_LOWPOWER   = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NETH-1:0]      RX_VALID,
  output logic [NETH-1:0]      RX_READY,
  input  logic [NETH*MACW-1:0] RX_SRCMAC,
  input  logic                 TX_VALID,
  output logic                 TX_READY,
  input  logic [MACW-1:0]      TX_DSTMAC,
  input  logic [NETH-1:0]      TX_SRCPORT,
  output logic                 TXR_VALID,
  input  logic                 TXR_READY,
  output logic [NETH-1:0]      TXR_PORT,
  output logic                 TXR_HIT,
  output logic [LGTBL:0]       o_count
);
  localparam int NTBL = 1 << LGTBL;
  localparam int PW   = (NETH > 1) ? $clog2(NETH) : 1;

  logic [PW-1:0]     rr_q, rr_d;
  logic [LGTICK-1:0] tick_cnt_q, tick_cnt_d;
  logic [LGTBL:0]    cnt_q, cnt_d;
  logic              txr_vld_q, txr_vld_d;
  logic [NETH-1:0]   txr_port_q, txr_port_d;
  logic              txr_hit_q, txr_hit_d;

  logic                             tick;
  logic                             gnt_any;
  logic [PW-1:0]                    gnt_idx;
  logic [MACW-1:0]                  learn_mac;
  logic                             learn_en;
  logic [NTBL-1:0]                  ent_vld, ent_vld_nxt, ent_wr;
  logic [NTBL-1:0][LGAGE-1:0]       ent_age;
  logic [NTBL-1:0][MACW-1:0]        ent_mac;
  logic [NTBL-1:0][PW-1:0]          ent_port;
  logic                             hit_any, free_any;
  logic [LGTBL-1:0]                 hit_idx, free_idx, old_idx, wr_sel;
  logic [LGAGE-1:0]                 old_age;
  logic                             lk_hit;
  logic [PW-1:0]                    lk_pidx;
  logic [NETH-1:0]                  lk_oh, res_port;
  logic                             res_hit, tx_acc;

  // Round-robin: first requester at or after the pointer, wrapping.
  always_comb begin
    int p;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    rr_d     = rr_q;
    RX_READY = '0;
    for (int i = 0; i < NETH; i++) begin
      p = int'(rr_q) + i;
      if (p >= NETH) p = p - NETH;
      if (!gnt_any && RX_VALID[p]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(p);
      end
    end
    if (gnt_any) begin
      RX_READY[gnt_idx] = 1'b1;
      rr_d = (gnt_idx == PW'(NETH-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign learn_mac = RX_SRCMAC[int'(gnt_idx)*MACW +: MACW];
  // Group-address sources are consumed but never learned.
  assign learn_en  = gnt_any && !learn_mac[MACW-8];

  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int e = NTBL-1; e >= 0; e--) begin
      if (ent_vld[e] && ent_mac[e] == learn_mac) begin
        hit_any = 1'b1;
        hit_idx = LGTBL'(e);
      end
      if (!ent_vld[e]) begin
        free_any = 1'b1;
        free_idx = LGTBL'(e);
      end
    end
    old_idx = '0;
    old_age = ent_age[0];
    for (int e = 1; e < NTBL; e++) begin
      if (ent_age[e] < old_age) begin
        old_age = ent_age[e];
        old_idx = LGTBL'(e);
      end
    end
    wr_sel = hit_any ? hit_idx : (free_any ? free_idx : old_idx);
    ent_wr = '0;
    if (learn_en) ent_wr[wr_sel] = 1'b1;
  end

  assign tick_cnt_d = tick_cnt_q + 1'b1;
  assign tick       = &tick_cnt_q;

  for (genvar e = 0; e < NTBL; e++) begin : g_ent
    route_learntbl_entry #(
      .MACW(MACW), .PW(PW), .LGAGE(LGAGE)
    ) u_ent (
      .clk    (i_clk),
      .rst    (i_reset),
      .wr_en  (ent_wr[e]),
      .tick   (tick),
      .wr_mac (learn_mac),
      .wr_port(gnt_idx),
      .vld    (ent_vld[e]),
      .vld_nxt(ent_vld_nxt[e]),
      .age    (ent_age[e]),
      .mac    (ent_mac[e]),
      .port   (ent_port[e])
    );
  end

  always_comb begin
    cnt_d = '0;
    for (int e = 0; e < NTBL; e++) cnt_d = cnt_d + (LGTBL+1)'(ent_vld_nxt[e]);
  end

  // Lookup reads the table as it stands before this edge's learn write.
  always_comb begin
    lk_hit  = 1'b0;
    lk_pidx = '0;
    for (int e = 0; e < NTBL; e++) begin
      if (ent_vld[e] && ent_mac[e] == TX_DSTMAC) begin
        lk_hit  = 1'b1;
        lk_pidx = ent_port[e];
      end
    end
    lk_oh          = '0;
    lk_oh[lk_pidx] = 1'b1;
    if (TX_DSTMAC[MACW-8] || !lk_hit) begin
      res_port = BROADCAST_PORT & ~TX_SRCPORT;
      res_hit  = 1'b0;
    end else begin
      res_port = lk_oh & ~TX_SRCPORT;
      res_hit  = 1'b1;
    end
  end

  assign TX_READY = !txr_vld_q || TXR_READY;
  assign tx_acc   = TX_VALID && TX_READY;

  always_comb begin
    txr_vld_d  = txr_vld_q;
    txr_port_d = txr_port_q;
    txr_hit_d  = txr_hit_q;
    if (tx_acc) begin
      txr_vld_d  = 1'b1;
      txr_port_d = res_port;
      txr_hit_d  = res_hit;
    end else if (TXR_READY) begin
      txr_vld_d = 1'b0;
      if (OPT_LOWPOWER) begin
        txr_port_d = '0;
        txr_hit_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rr_q       <= '0;
      tick_cnt_q <= '0;
      cnt_q      <= '0;
      txr_vld_q  <= 1'b0;
      txr_port_q <= '0;
      txr_hit_q  <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      tick_cnt_q <= tick_cnt_d;
      cnt_q      <= cnt_d;
      txr_vld_q  <= txr_vld_d;
      txr_port_q <= txr_port_d;
      txr_hit_q  <= txr_hit_d;
    end
  end

  assign TXR_VALID = txr_vld_q;
  assign TXR_PORT  = txr_port_q;
  assign TXR_HIT   = txr_hit_q;
  assign o_count   = cnt_q;
endmodule

// File: tb/tb_route_learntbl.sv
// Bench for route_learntbl: directed scenarios plus random traffic, all
// checked cycle by cycle against a table model built from the forwarding rules.
module tb_route_learntbl;
  localparam int NTBL = 4;

  logic         i_clk = 1'b0, i_reset = 1'b0;
  logic [3:0]   RX_VALID = '0, RX_READY;
  logic [191:0] RX_SRCMAC = '0;
  logic         TX_VALID = 1'b0, TX_READY;
  logic [47:0]  TX_DSTMAC = '0;
  logic [3:0]   TX_SRCPORT = '0;
  logic         TXR_VALID, TXR_READY = 1'b0, TXR_HIT;
  logic [3:0]   TXR_PORT;
  logic [2:0]   o_count;

  int tests = 0, fails = 0;

  bit          m_vld[NTBL];
  int          m_age[NTBL];
  logic [47:0] m_mac[NTBL];
  int          m_port[NTBL];
  int          m_ptr, m_edges;
  bit          e_vld, e_hit;
  logic [3:0]  e_port;

  route_learntbl #(
    .NETH(4), .MACW(48), .LGTBL(2), .LGAGE(2), .LGTICK(4),
    .BROADCAST_PORT(4'b1111), .OPT_LOWPOWER(1'b1)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .RX_VALID(RX_VALID), .RX_READY(RX_READY), .RX_SRCMAC(RX_SRCMAC),
    .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TX_DSTMAC(TX_DSTMAC),
    .TX_SRCPORT(TX_SRCPORT),
    .TXR_VALID(TXR_VALID), .TXR_READY(TXR_READY), .TXR_PORT(TXR_PORT),
    .TXR_HIT(TXR_HIT), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] mk(input int n);
    return {8'h02, 32'h0, 8'(n)};
  endfunction

  function automatic logic [191:0] at(input int p, input logic [47:0] m);
    logic [191:0] r = '0;
    r[p*48 +: 48] = m;
    return r;
  endfunction

  function automatic logic [47:0] pool(input int i);
    return (i < 6) ? mk(48 + i) : {8'h01, 32'h0, 8'(i)};
  endfunction

  function automatic int m_grant(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int e = 0; e < NTBL; e++) c += int'(m_vld[e]);
    return c;
  endfunction

  task automatic m_reset();
    for (int e = 0; e < NTBL; e++) begin m_vld[e] = 0; m_age[e] = 0; end
    m_ptr = 0; m_edges = 0; e_vld = 0; e_hit = 0; e_port = '0;
  endtask

  task automatic do_reset();
    RX_VALID = '0; RX_SRCMAC = '0; TX_VALID = 0; TX_DSTMAC = '0; TX_SRCPORT = '0; TXR_READY = 0;
    i_reset = 1'b1;
    #1;
    chk("rst_txr_valid", TXR_VALID, 0);
    chk("rst_txr_port", TXR_PORT, 0);
    chk("rst_count", o_count, 0);
    chk("rst_rx_ready", RX_READY, 0);
    m_reset();
    @(posedge i_clk);
    #1 i_reset = 1'b0;
  endtask

  // One clock: drive, check combinational handshakes, step the model, check registers.
  task automatic cyc(input logic [3:0] rxv, input logic [191:0] rxm, input bit txv,
                     input logic [47:0] dst, input logic [3:0] src, input bit txrr);
    int g, tgt;
    bit rdy, tick;
    logic [47:0] lm;
    RX_VALID = rxv; RX_SRCMAC = rxm; TX_VALID = txv;
    TX_DSTMAC = dst; TX_SRCPORT = src; TXR_READY = txrr;
    #1;
    g   = m_grant(rxv);
    rdy = !e_vld || txrr;
    chk("rx_ready", RX_READY, (g < 0) ? 64'd0 : (64'd1 << g));
    chk("tx_ready", TX_READY, rdy);
    @(posedge i_clk);
    if (txv && rdy) begin
      e_vld = 1; e_hit = 0; e_port = 4'hF & ~src;
      if (!dst[40])
        for (int e = 0; e < NTBL; e++)
          if (m_vld[e] && m_mac[e] == dst) begin
            e_hit = 1; e_port = (4'b0001 << m_port[e]) & ~src;
          end
    end else if (txrr) begin
      e_vld = 0; e_hit = 0; e_port = '0;
    end
    tgt = -1;
    lm  = '0;
    if (g >= 0) begin
      m_ptr = (g + 1) % 4;
      lm = rxm[g*48 +: 48];
      if (!lm[40]) begin
        for (int e = 0; e < NTBL; e++) if (m_vld[e] && m_mac[e] == lm) tgt = e;
        if (tgt < 0) for (int e = 0; e < NTBL; e++) if (!m_vld[e] && tgt < 0) tgt = e;
        if (tgt < 0) begin
          tgt = 0;
          for (int e = 1; e < NTBL; e++) if (m_age[e] < m_age[tgt]) tgt = e;
        end
      end
    end
    m_edges++;
    tick = (m_edges % 16 == 0);
    for (int e = 0; e < NTBL; e++) begin
      if (e == tgt) begin
        m_vld[e] = 1; m_age[e] = 3; m_mac[e] = lm; m_port[e] = g;
      end else if (tick && m_vld[e]) begin
        m_age[e]--;
        if (m_age[e] == 0) m_vld[e] = 0;
      end
    end
    #1;
    chk("txr_valid", TXR_VALID, e_vld);
    chk("txr_port", TXR_PORT, e_port);
    chk("txr_hit", TXR_HIT, e_hit);
    chk("count", o_count, m_count());
  endtask

  task automatic idle(input int n);
    repeat (n) cyc('0, '0, 0, '0, '0, 1);
  endtask

  initial begin
    logic [191:0] rxm;
    #3;
    do_reset();

    // learn on port 2, look up from port 0
    cyc(4'b0100, at(2, mk(1)), 0, '0, '0, 1);
    cyc('0, '0, 1, mk(1), 4'b0001, 1);
    chk("learn_lookup_port", TXR_PORT, 4'b0100);
    chk("learn_lookup_hit", TXR_HIT, 1);
    cyc('0, '0, 1, mk(8'h99), 4'b0010, 1);
    chk("miss_port", TXR_PORT, 4'b1101);
    chk("miss_hit", TXR_HIT, 0);
    cyc('0, '0, 1, 48'hFFFF_FFFF_FFFF, 4'b1000, 1);
    chk("bcast_port", TXR_PORT, 4'b0111);
    cyc('0, '0, 1, mk(1), 4'b0100, 1);
    chk("same_port_drop", TXR_PORT, 4'b0000);
    idle(1);
    chk("lowpower_port", TXR_PORT, 4'b0000);

    // all four ports requesting: round-robin grants 0..3
    do_reset();
    rxm = at(0, mk(16)) | at(1, mk(17)) | at(2, mk(18)) | at(3, mk(19));
    repeat (4) cyc(4'b1111, rxm, 0, '0, '0, 1);
    chk("rr_fill_count", o_count, 4);

    // aging out without refresh
    do_reset();
    cyc(4'b0001, at(0, mk(5)), 0, '0, '0, 1);
    idle(48);
    chk("aged_out_count", o_count, 0);

    // periodic refresh keeps it alive
    do_reset();
    for (int k = 0; k < 60; k++)
      if (k % 10 == 0) cyc(4'b0001, at(0, mk(5)), 0, '0, '0, 1);
      else idle(1);
    chk("refreshed_count", o_count, 1);

    // full table: oldest entry is the one replaced
    do_reset();
    for (int k = 0; k < 4; k++) cyc(4'b0001 << k, at(k, mk(32 + k)), 0, '0, '0, 1);
    idle(13);
    for (int k = 0; k < 3; k++) cyc(4'b0001 << k, at(k, mk(32 + k)), 0, '0, '0, 1);
    cyc(4'b0010, at(1, mk(40)), 0, '0, '0, 1);
    chk("replace_count", o_count, 4);
    cyc('0, '0, 1, mk(40), 4'b0001, 1);
    chk("replace_new_hit", TXR_HIT, 1);
    chk("replace_new_port", TXR_PORT, 4'b0010);
    cyc('0, '0, 1, mk(35), 4'b0001, 1);
    chk("replace_old_miss", TXR_HIT, 0);

    // stalled result, then reset drops it
    do_reset();
    cyc('0, '0, 1, mk(7), 4'b0001, 0);
    cyc('0, '0, 1, mk(7), 4'b0001, 0);
    chk("stall_tx_ready", TX_READY, 0);
    chk("stall_port", TXR_PORT, 4'b1110);
    do_reset();
    idle(2);
    chk("reset_drops_result", TXR_VALID, 0);

    // random traffic
    do_reset();
    for (int n = 0; n < 500; n++) begin
      logic [191:0] rm;
      logic [47:0]  d;
      if ($urandom_range(0, 149) == 0) do_reset();
      rm = '0;
      for (int p = 0; p < 4; p++) rm[p*48 +: 48] = pool($urandom_range(0, 7));
      d = ($urandom_range(0, 9) == 0) ? 48'hFFFF_FFFF_FFFF : pool($urandom_range(0, 7));
      cyc(($urandom_range(0, 3) == 0) ? 4'(($urandom_range(0, 15))) : 4'b0000, rm,
          $urandom_range(0, 1) == 1, d, 4'b0001 << $urandom_range(0, 3),
          $urandom_range(0, 9) < 7);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/route_learntbl.md
ROUTE_LEARNTBL -- requirements
Module: route_learntbl

Interface
REQ-001 SHALL have parameter NETH, default 4, number of Ethernet ports.
REQ-002 SHALL have parameter MACW, default 48, MAC address width.
REQ-003 SHALL have parameter LGTBL, default 6, log2 of table entries (NTBL=2^LGTBL).
REQ-004 SHALL have parameter LGAGE, default 4, entry age counter width.
REQ-005 SHALL have parameter LGTICK, default 20, log2 of clocks per age tick.
REQ-006 SHALL have parameter BROADCAST_PORT, default all ones [NETH], flood mask.
REQ-007 SHALL have parameter OPT_LOWPOWER, default 0, zero result data when not valid.
REQ-008 SHALL have port i_clk input 1 -- sole clock; one clock; all state on its rising edge.
REQ-009 SHALL have port i_reset input 1 -- reset, asynchronous and active-high.
REQ-010 SHALL have RX_VALID input NETH, RX_READY output NETH, RX_SRCMAC input NETH*MACW -- learn requests, port k uses RX_SRCMAC[k*MACW +: MACW].
REQ-011 SHALL have TX_VALID input 1, TX_READY output 1, TX_DSTMAC input MACW, TX_SRCPORT input NETH (one-hot ingress port) -- lookup request.
REQ-012 SHALL have TXR_VALID output 1, TXR_READY input 1, TXR_PORT output NETH, TXR_HIT output 1 -- lookup result.
REQ-013 SHALL have o_count output LGTBL+1 -- number of valid entries.

Function
REQ-014 Learn arbitration: round-robin over RX_VALID; pointer advances past the granted port after each grant; at most one learn per cycle.
REQ-015 RX_READY SHALL be one-hot grant (zero when RX_VALID==0); a learn occurs when RX_VALID&RX_READY nonzero.
REQ-016 Learn, MAC matches valid entry: overwrite port index, reload age to all ones.
REQ-017 Learn, no match, table not full: write lowest-index invalid entry, age all ones, valid=1.
REQ-018 Learn, no match, table full: replace entry with smallest age; ties to lowest index.
REQ-019 Aging: free-running LGTICK-bit counter; tick on wrap to zero. Each tick, every valid non-refreshed entry decrements age; entry with age 1 at tick becomes invalid, age 0.
REQ-020 Learn and tick on same entry same cycle: learn wins (age all ones, valid).
REQ-021 o_count SHALL be registered and equal popcount of valid bits; updated same edge as valid bits.
REQ-022 Lookup handshake: TX_READY = !TXR_VALID || TXR_READY; accept on TX_VALID&&TX_READY; result TXR_VALID one cycle after accept.
REQ-023 TXR_VALID holds with TXR_PORT/TXR_HIT stable until TXR_READY; back-to-back accepts allowed at full throughput.
REQ-024 Destination with group bit TX_DSTMAC[MACW-8]=1 (includes all-ones broadcast): TXR_PORT = BROADCAST_PORT & ~TX_SRCPORT, TXR_HIT=0.
REQ-025 Unicast hit: TXR_PORT = onehot(entry port) & ~TX_SRCPORT, TXR_HIT=1; result zero (drop) when entry port equals source port.
REQ-026 Unicast miss: TXR_PORT = BROADCAST_PORT & ~TX_SRCPORT, TXR_HIT=0.
REQ-027 Lookup and learn same cycle: lookup sees table state before that edge's write.
REQ-028 Multicast/broadcast source MACs SHALL NOT be learned; request still consumed.
REQ-029 OPT_LOWPOWER=1: TXR_PORT and TXR_HIT zero whenever TXR_VALID=0.

Reset
REQ-030 Asserting i_reset SHALL immediately clear all valid bits, ages, tick counter, round-robin pointer (port 0 highest priority), TXR_VALID, TXR_PORT, TXR_HIT, o_count; RX_READY then zero only if RX_VALID zero.
REQ-031 Reset mid-lookup SHALL drop the pending result; no TXR_VALID for it after release.
REQ-032 Table MAC/port storage need not be reset.

Verification
REQ-033 Learn 02:00:00:00:00:01 on port 2, next cycle lookup it from port 0 -> TXR_VALID one cycle after accept, TXR_PORT=4'b0100, TXR_HIT=1.
REQ-034 Lookup unknown unicast from port 1 (NETH=4) -> TXR_PORT=4'b1101, TXR_HIT=0; lookup FF:FF:FF:FF:FF:FF from port 3 -> 4'b0111, HIT=0.
REQ-035 RX_VALID=4'b1111 held four cycles with distinct MACs -> grants 0,1,2,3 in order, o_count=4.
REQ-036 LGTICK=4, LGAGE=2: learn one MAC, no refresh -> invalid after third tick (48 cycles max), o_count back to 0; refresh every tick keeps it valid.
REQ-037 LGTBL=2: fill 4 entries, refresh three, learn fifth MAC -> unrefreshed entry replaced, o_count stays 4.
REQ-038 Hold TXR_READY=0 with TX_VALID=1 -> TX_READY=0 after first accept, result stable; assert i_reset -> TXR_VALID=0 same cycle.
